// File: rtl/sar_search.sv
// sar_search -- successive-approximation search controller.
//
// Drives a W-bit trial code into an external combinational magnitude
// comparator and resolves one bit per clock, MSB first. The result is the
// largest code not exceeding the comparator's target. exact marks a hit.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start             request a new search (ignored while busy)
//   trial   [W-1:0]   registered code presented to the comparator
//   cmp_eq/gt/lt      comparator verdict for the current trial
//   busy              search in progress
//   done              one-cycle pulse when result is valid
//   result  [W-1:0]   final code, held until the next accepted start
//   exact             an eq verdict ended the search
//   err               sticky malformed-verdict flag, cleared on start
module sar_search #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [W-1:0] trial,
  input  logic         cmp_eq,
  input  logic         cmp_gt,
  input  logic         cmp_lt,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         exact,
  output logic         err
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] SEARCH = 1'b1;

  localparam logic [W-1:0]  MSB_CODE = {1'b1, {(W-1){1'b0}}};
  localparam logic [IW-1:0] IDX_TOP  = IW'(W - 1);

  logic [0:0]    r_state;
  logic [IW-1:0] r_idx;
  logic [W-1:0]  r_trial;
  logic [W-1:0]  r_result;
  logic          r_busy;
  logic          r_done;
  logic          r_exact;
  logic          r_err;

  logic          w_bad;
  logic [W-1:0]  w_upd;
  logic [W-1:0]  w_step;

  // Verdict decode. Priority is eq > gt > lt, and "no verdict" behaves as lt,
  // so only gt (without eq) can clear the bit under test.
  // NOTE: every signal written here gets a default first so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_bad  = ~(cmp_eq | cmp_gt | cmp_lt)
           | (cmp_eq & cmp_gt) | (cmp_eq & cmp_lt) | (cmp_gt & cmp_lt);
    w_upd  = r_trial;
    if (!cmp_eq && cmp_gt) begin
      w_upd[r_idx] = 1'b0;
    end
    // Next trial also sets the next-lower bit as the new guess.
    w_step = w_upd;
    if (r_idx != '0) begin
      w_step[r_idx - 1'b1] = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values and the block order does not matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_trial  <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_exact  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_trial <= MSB_CODE;
            r_idx   <= IDX_TOP;
            r_busy  <= 1'b1;
            r_exact <= 1'b0;
            r_err   <= 1'b0;
            r_state <= SEARCH;
          end
        end
        SEARCH: begin
          if (w_bad) begin
            r_err <= 1'b1;
          end
          if (cmp_eq) begin
            // Exact hit: trial is left as-is.
            r_result <= r_trial;
            r_exact  <= 1'b1;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end else if (r_idx != '0) begin
            r_trial <= w_step;
            r_idx   <= r_idx - 1'b1;
          end else begin
            r_trial  <= w_upd;
            r_result <= w_upd;
            r_exact  <= 1'b0;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign trial  = r_trial;
  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign exact  = r_exact;
  assign err    = r_err;

endmodule
